// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master, split-capable bus arbiter.
package bus_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    SPLIT_IDLE = 2'd2,
    SPLIT_BUSY = 2'd3
  } arb_state_t;

  localparam logic [1:0] M1 = 2'b01;
  localparam logic [1:0] M2 = 2'b10;

  localparam int DEFAULT_GRANT_TIMEOUT = 1024;
endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-side bus signals: master requests, bus/slave pulses and the grant outputs.
interface bus_arbiter_if;
  logic [1:0] mreq;
  logic       tx_done;
  logic       split;
  logic       split_ready;
  logic [1:0] mgrant;
  logic       bus_busy;
  logic [1:0] split_owner;
  logic       timeout_err;

  modport slave (
    input  mreq, tx_done, split, split_ready,
    output mgrant, bus_busy, split_owner, timeout_err
  );

  modport master (
    output mreq, tx_done, split, split_ready,
    input  mgrant, bus_busy, split_owner, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational one-hot winner select for two masters.
// BUS_ARB_ROUND_ROBIN_EN: ties go to the master that did not own the bus last; else master 1 wins.
module arb_pick
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_owner,
  output logic [1:0] win
);
`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    win = req;
    if (req == 2'b11) win = (last_owner == M1) ? M2 : M1;
  end
`else
  logic unused_last;
  assign unused_last = ^last_owner;

  always_comb begin
    win = req;
    if (req == 2'b11) win = M1;
  end
`endif
endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split parking/resume and grant-tenure timeout.
// Optional BUS_ARB_ROUND_ROBIN_EN builds the last-owner register for round-robin ties.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
  input  logic         clock,
  input  logic         rst,
  bus_arbiter_if.slave bus
);
  localparam int            CW       = $clog2(GRANT_TIMEOUT);
  localparam logic [CW-1:0] TEN_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] TEN_MAX  = {CW{1'b1}};

  arb_state_t    state;
  logic [1:0]    owner, parked, last_owner, req_elig, win, lender;
  logic          ready_seen, busy, terr, expired, resume;
  logic [CW-1:0] ten;

  // The current owner and any parked master are excluded from arbitration.
  assign req_elig = bus.mreq & ~owner & ~parked;
  assign lender   = bus.mreq & ~parked;
  assign expired  = (|owner) && (ten == TEN_LAST);
  assign resume   = ready_seen | bus.split_ready;

  arb_pick u_pick (
    .req        (req_elig),
    .last_owner (last_owner),
    .win        (win)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)        last_owner <= M2;
    else if (|owner) last_owner <= owner;
  end
`else
  assign last_owner = M2;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      parked     <= '0;
      ready_seen <= 1'b0;
      ten        <= '0;
      busy       <= 1'b0;
      terr       <= 1'b0;
    end else begin
      terr <= 1'b0;
      if (|owner && ten != TEN_MAX) ten <= ten + 1'b1;

      case (state)
        IDLE: begin
          if (|win) begin
            state <= BUSY;
            owner <= win;
            busy  <= 1'b1;
            ten   <= '0;
          end
        end

        BUSY: begin
          // tx_done beats split, and split beats a same-cycle timeout.
          if (bus.tx_done || (expired && !bus.split)) begin
            terr  <= !bus.tx_done;
            owner <= win;
            busy  <= |win;
            ten   <= '0;
            state <= (|win) ? BUSY : IDLE;
          end else if (bus.split) begin
            parked <= owner;
            ten    <= '0;
            if (|(bus.mreq & ~owner)) begin
              owner <= ~owner;
              state <= SPLIT_BUSY;
            end else begin
              owner <= '0;
              busy  <= 1'b0;
              state <= SPLIT_IDLE;
            end
          end
        end

        SPLIT_IDLE: begin
          if (resume) begin
            owner      <= parked;
            parked     <= '0;
            ready_seen <= 1'b0;
            busy       <= 1'b1;
            ten        <= '0;
            state      <= BUSY;
          end else if (|lender) begin
            owner <= lender;
            busy  <= 1'b1;
            ten   <= '0;
            state <= SPLIT_BUSY;
          end
        end

        SPLIT_BUSY: begin
          // A second split is ignored here; the lender keeps the bus.
          if (bus.tx_done || expired) begin
            terr       <= !bus.tx_done;
            ten        <= '0;
            ready_seen <= 1'b0;
            if (resume) begin
              owner  <= parked;
              parked <= '0;
              state  <= BUSY;
            end else begin
              owner <= '0;
              busy  <= 1'b0;
              state <= SPLIT_IDLE;
            end
          end else if (bus.split_ready) begin
            ready_seen <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mgrant      = owner;
  assign bus.bus_busy    = busy;
  assign bus.split_owner = parked;
  assign bus.timeout_err = terr;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner sequences and a randomized run
// against a master-number reference model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int TO      = 8;
  localparam int TEN_SAT = (1 << $clog2(TO)) - 1;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  bus_arbiter_if bus();

  bus_arbiter #(.GRANT_TIMEOUT(TO)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: masters as numbers 0 (none), 1, 2.
  int m_owner, m_parked, m_ten, m_last;
  bit m_ready, m_terr;

  typedef struct {
    logic [1:0] mreq;
    bit         tx_done;
    bit         split;
    bit         split_ready;
    logic [1:0] grant;
    logic [1:0] sowner;
    bit         terr;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [1:0] oh(input int m);
    return (m == 0) ? 2'b00 : ((m == 1) ? 2'b01 : 2'b10);
  endfunction

  function automatic int pick(input logic [1:0] c);
    if (c == 2'b11) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (c[0]) return 1;
    if (c[1]) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_parked = 0; m_ten = 0; m_last = 2;
    m_ready = 0; m_terr = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input bit d, input bit s, input bit y);
    int nxt;
    bit expd;
    nxt    = m_owner;
    m_terr = 0;
    expd   = (m_owner != 0) && (m_ten == TO - 1);
    if (m_parked == 0) begin
      if (m_owner == 0) nxt = pick(r);
      else if (d || (expd && !s)) begin
        m_terr = !d;
        nxt    = pick(r & ~oh(m_owner));
      end else if (s) begin
        m_parked = m_owner;
        nxt      = r[2 - m_owner] ? 3 - m_owner : 0;
      end
    end else begin
      if (m_owner == 0) begin
        if (m_ready || y) begin
          nxt = m_parked; m_parked = 0; m_ready = 0;
        end else if (r[2 - m_parked]) nxt = 3 - m_parked;
      end else if (d || expd) begin
        m_terr = !d;
        if (m_ready || y) begin
          nxt = m_parked; m_parked = 0;
        end else nxt = 0;
        m_ready = 0;
      end else if (y) m_ready = 1;
    end
    if (nxt != m_owner) m_ten = 0;
    else if (m_owner != 0 && m_ten < TEN_SAT) m_ten++;
    if (nxt != 0) m_last = nxt;
    m_owner = nxt;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".mgrant"},      bus.mgrant,              oh(m_owner));
    check({tag, ".split_owner"}, bus.split_owner,         oh(m_parked));
    check({tag, ".bus_busy"},    {1'b0, bus.bus_busy},    {1'b0, m_owner != 0});
    check({tag, ".timeout_err"}, {1'b0, bus.timeout_err}, {1'b0, m_terr});
  endtask

  // Called at a negedge: drive, let the DUT sample, then compare on the next negedge.
  task automatic drive_cycle(input logic [1:0] r, input bit d, input bit s, input bit y, input string tag);
    bus.mreq = r; bus.tx_done = d; bus.split = s; bus.split_ready = y;
    @(posedge clock);
    model_step(r, d, s, y);
    @(negedge clock);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.mreq = '0; bus.tx_done = 0; bus.split = 0; bus.split_ready = 0;
    repeat (2) @(negedge clock);
    model_reset();
    check_model("reset");
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    bit d, s, y;

    vecs[0]  = '{2'b11, 0, 0, 0, 2'b01, 2'b00, 0};
    vecs[1]  = '{2'b11, 1, 0, 0, 2'b10, 2'b00, 0};
    vecs[2]  = '{2'b10, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[3]  = '{2'b01, 0, 0, 0, 2'b01, 2'b00, 0};
    vecs[4]  = '{2'b11, 0, 1, 0, 2'b10, 2'b01, 0};
    vecs[5]  = '{2'b11, 0, 0, 1, 2'b10, 2'b01, 0};
    vecs[6]  = '{2'b11, 0, 1, 0, 2'b10, 2'b01, 0};
    vecs[7]  = '{2'b11, 1, 0, 0, 2'b01, 2'b00, 0};
    vecs[8]  = '{2'b11, 1, 0, 0, 2'b10, 2'b00, 0};
    vecs[9]  = '{2'b10, 1, 1, 0, 2'b00, 2'b00, 0};
    vecs[10] = '{2'b01, 0, 0, 0, 2'b01, 2'b00, 0};
    vecs[11] = '{2'b01, 0, 1, 0, 2'b00, 2'b01, 0};
    vecs[12] = '{2'b01, 0, 0, 0, 2'b00, 2'b01, 0};
    vecs[13] = '{2'b01, 0, 0, 1, 2'b01, 2'b00, 0};
    vecs[14] = '{2'b01, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[15] = '{2'b00, 0, 0, 0, 2'b00, 2'b00, 0};

    // Directed table from reset.
    do_reset();
    foreach (vecs[i]) begin
      bus.mreq = vecs[i].mreq; bus.tx_done = vecs[i].tx_done;
      bus.split = vecs[i].split; bus.split_ready = vecs[i].split_ready;
      @(posedge clock);
      model_step(vecs[i].mreq, vecs[i].tx_done, vecs[i].split, vecs[i].split_ready);
      @(negedge clock);
      check($sformatf("vec%0d.mgrant", i),      bus.mgrant,              vecs[i].grant);
      check($sformatf("vec%0d.split_owner", i), bus.split_owner,         vecs[i].sowner);
      check($sformatf("vec%0d.bus_busy", i),    {1'b0, bus.bus_busy},    {1'b0, vecs[i].grant != 2'b00});
      check($sformatf("vec%0d.timeout_err", i), {1'b0, bus.timeout_err}, {1'b0, vecs[i].terr});
    end

    // Tenure timeout: master 2 held without tx_done is revoked at the ninth edge.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive_cycle(2'b10, 0, 0, 0, "to_model");
      check($sformatf("timeout%0d.mgrant", k), bus.mgrant, (k <= 8) ? 2'b10 : 2'b00);
      check($sformatf("timeout%0d.err", k), {1'b0, bus.timeout_err}, {1'b0, k == 9});
    end
    drive_cycle(2'b00, 0, 0, 0, "to_after");
    check("timeout_after.err", {1'b0, bus.timeout_err}, 2'b00);

    // Split arriving in the same cycle as the timeout wins.
    do_reset();
    repeat (8) drive_cycle(2'b11, 0, 0, 0, "split_to_hold");
    drive_cycle(2'b11, 0, 1, 0, "split_to");
    check("split_to.mgrant", bus.mgrant, 2'b10);
    check("split_to.split_owner", bus.split_owner, 2'b01);
    check("split_to.err", {1'b0, bus.timeout_err}, 2'b00);
    drive_cycle(2'b01, 1, 0, 0, "lender_done");
    check("lender_done.mgrant", bus.mgrant, 2'b00);
    drive_cycle(2'b01, 0, 0, 1, "resume");
    check("resume.mgrant", bus.mgrant, 2'b01);
    check("resume.split_owner", bus.split_owner, 2'b00);

    // Asynchronous reset while in SPLIT_BUSY.
    do_reset();
    drive_cycle(2'b11, 0, 0, 0, "pre_rst_grant");
    drive_cycle(2'b11, 0, 1, 0, "pre_rst_split");
    #2 rst = 1'b0;
    #1;
    check("async_rst.mgrant", bus.mgrant, 2'b00);
    check("async_rst.split_owner", bus.split_owner, 2'b00);
    check("async_rst.bus_busy", {1'b0, bus.bus_busy}, 2'b00);
    check("async_rst.err", {1'b0, bus.timeout_err}, 2'b00);
    model_reset();
    bus.mreq = '0; bus.tx_done = 0; bus.split = 0; bus.split_ready = 0;
    @(negedge clock);
    rst = 1'b1;
    drive_cycle(2'b00, 0, 0, 0, "post_rst");

`ifdef BUS_ARB_ROUND_ROBIN_EN
    do_reset();
    drive_cycle(2'b11, 0, 0, 0, "rr0");
    check("rr0.mgrant", bus.mgrant, 2'b01);
    drive_cycle(2'b11, 1, 0, 0, "rr1");
    check("rr1.mgrant", bus.mgrant, 2'b10);
    drive_cycle(2'b11, 1, 0, 0, "rr2");
    check("rr2.mgrant", bus.mgrant, 2'b01);
    drive_cycle(2'b11, 1, 0, 0, "rr3");
    check("rr3.mgrant", bus.mgrant, 2'b10);
    drive_cycle(2'b10, 1, 0, 0, "rr_idle");
    drive_cycle(2'b01, 0, 0, 0, "rr_m1");
    drive_cycle(2'b01, 1, 0, 0, "rr_m1_done");
    drive_cycle(2'b11, 0, 0, 0, "rr_tie");
    check("rr_tie.mgrant", bus.mgrant, 2'b10);
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 9) == 0);
      y = ($urandom_range(0, 7) == 0);
      drive_cycle(r, d, s, y, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
